tb_eoc_monitor: RTL and testbench

// Parametrised end-of-computation (EOC) monitor for the simulation testharness.

---
 rtl/tb_eoc_monitor.sv | 93 +++++++++
 tb/tb_tb_eoc_monitor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tb_eoc_monitor.sv
// tb_eoc_monitor: tracks per-channel EOC writes, aggregates exit codes, optional timeout.
// Define TB_EOC_FINISH_EN to report and $finish on reaching DONE/TIMEOUT (simulation only).
module tb_eoc_monitor #(
    parameter int NumChannels   = 1,
    parameter int DataWidth     = 32,
    parameter int CntWidth      = 64,
    parameter int TimeoutCycles = 0,
    parameter int ChanIdxW      = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [ChanIdxW-1:0]    wr_chan_i,
    input  logic [DataWidth-1:0]   wr_data_i,
    output logic [NumChannels-1:0] chan_done_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [DataWidth-2:0]   exit_code_o,
    output logic [CntWidth-1:0]    cycles_o,
    output logic                   err_o
);
    typedef enum logic [1:0] {RUN, DONE, TIMEOUT} state_e;
    state_e state_q, state_d;
    logic [NumChannels-1:0] chan_q, set_mask;
    logic [DataWidth-2:0] code_q [NumChannels];
    logic [DataWidth-2:0] code_d [NumChannels];
    logic [DataWidth-2:0] exit_q, exit_d, first_code;
    logic [CntWidth-1:0] cyc_q, cyc_d;
    logic ready_q, err_q, err_d, hs, in_range, all_done, tmo_hit;
    always_comb begin
        hs         = wr_valid_i & ready_q;
        in_range   = 32'(wr_chan_i) < NumChannels;
        set_mask   = '0;
        first_code = '0;
        for (int i = 0; i < NumChannels; i++) begin
            set_mask[i] = hs & wr_data_i[0] & in_range & (wr_chan_i == ChanIdxW'(i)) & ~chan_q[i];
            code_d[i]   = set_mask[i] ? wr_data_i[DataWidth-1:1] : code_q[i];
        end
        // descending scan leaves the lowest-index non-zero code
        for (int i = NumChannels - 1; i >= 0; i--)
            if (code_d[i] != '0) first_code = code_d[i];
        all_done = &(chan_q | set_mask);
        tmo_hit  = (TimeoutCycles != 0) && (cyc_q == CntWidth'(TimeoutCycles - 1));
        state_d  = state_q;
        exit_d   = exit_q;
        if (state_q == RUN) begin
            state_d = all_done ? DONE : tmo_hit ? TIMEOUT : RUN;
            exit_d  = all_done ? first_code : tmo_hit ? '1 : exit_q;
        end
        cyc_d = (state_q == RUN && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
        err_d = err_q | (hs & ~in_range);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            chan_q  <= '0;
            exit_q  <= '0;
            cyc_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NumChannels; i++) code_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= state_d == RUN;
            chan_q  <= chan_q | set_mask;
            exit_q  <= exit_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
            for (int i = 0; i < NumChannels; i++) code_q[i] <= code_d[i];
        end
    end
    assign wr_ready_o  = ready_q;
    assign chan_done_o = chan_q;
    assign done_o      = state_q == DONE;
    assign timeout_o   = state_q == TIMEOUT;
    assign exit_code_o = exit_q;
    assign cycles_o    = cyc_q;
    assign err_o       = err_q;
`ifdef TB_EOC_FINISH_EN
    always @(posedge clk_i) begin
        if (rst_ni && state_q == RUN && state_d == DONE) begin
            for (int i = 0; i < NumChannels; i++) $display("EOC ch%0d code %0d", i, code_d[i]);
            $display("EOC cycles %0d", cyc_d);
            $finish;
        end else if (rst_ni && state_q == RUN && state_d == TIMEOUT) begin
            $error("EOC timeout");
            $finish;
        end
    end
`else
`endif
endmodule

// File: tb/tb_tb_eoc_monitor.sv
// tb_tb_eoc_monitor: two monitor instances (N=3 no timeout, N=4 timeout 60) vs a reference model.
module tb_tb_eoc_monitor;
    logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0;
    logic [1:0] wr_chan = '0;
    logic [15:0] wr_data = '0;
    logic a_rdy, a_done, a_to, a_err, b_rdy, b_done, b_to, b_err;
    logic [2:0] a_chan;
    logic [3:0] b_chan;
    logic [14:0] a_exit, b_exit;
    logic [7:0] a_cyc;
    logic [15:0] b_cyc;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    tb_eoc_monitor #(.NumChannels(3), .DataWidth(16), .CntWidth(8), .TimeoutCycles(0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(a_rdy),
        .wr_chan_i(wr_chan), .wr_data_i(wr_data), .chan_done_o(a_chan), .done_o(a_done),
        .timeout_o(a_to), .exit_code_o(a_exit), .cycles_o(a_cyc), .err_o(a_err));
    tb_eoc_monitor #(.NumChannels(4), .DataWidth(16), .CntWidth(16), .TimeoutCycles(60)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(b_rdy),
        .wr_chan_i(wr_chan), .wr_data_i(wr_data), .chan_done_o(b_chan), .done_o(b_done),
        .timeout_o(b_to), .exit_code_o(b_exit), .cycles_o(b_cyc), .err_o(b_err));

    int m_n[2] = '{3, 4};
    int m_t[2] = '{0, 60};
    longint m_max[2] = '{255, 65535};
    bit m_chan[2][4];
    int m_code[2][4];
    bit m_done[2], m_to[2], m_err[2], m_rdy[2];
    longint m_cyc[2];
    int m_exit[2];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] ev;
            string p;
            p = k ? "B_" : "A_";
            ev = '0;
            for (int i = 0; i < m_n[k]; i++) ev[i] = m_chan[k][i];
            chk({p, "chan"}, k ? 64'(b_chan) : 64'(a_chan), 64'(ev));
            chk({p, "done"}, k ? 64'(b_done) : 64'(a_done), 64'(m_done[k]));
            chk({p, "timeout"}, k ? 64'(b_to) : 64'(a_to), 64'(m_to[k]));
            chk({p, "exit"}, k ? 64'(b_exit) : 64'(a_exit), 64'(m_exit[k]));
            chk({p, "cycles"}, k ? 64'(b_cyc) : 64'(a_cyc), 64'(m_cyc[k]));
            chk({p, "err"}, k ? 64'(b_err) : 64'(a_err), 64'(m_err[k]));
            chk({p, "ready"}, k ? 64'(b_rdy) : 64'(a_rdy), 64'(m_rdy[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_chan[k][i] = 0;
                m_code[k][i] = 0;
            end
            m_done[k] = 0; m_to[k] = 0; m_err[k] = 0; m_rdy[k] = 0;
            m_cyc[k] = 0; m_exit[k] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input int c, input int d);
        for (int k = 0; k < 2; k++) begin
            bit all;
            if (!m_done[k] && !m_to[k]) begin
                if (v && m_rdy[k]) begin
                    if (c >= m_n[k]) m_err[k] = 1;
                    else if (d[0] && !m_chan[k][c]) begin
                        m_chan[k][c] = 1;
                        m_code[k][c] = (d >> 1) & 32'h7fff;
                    end
                end
                all = 1;
                for (int i = 0; i < m_n[k]; i++) all &= m_chan[k][i];
                if (all) begin
                    m_done[k] = 1;
                    m_exit[k] = 0;
                    for (int i = 0; i < m_n[k]; i++) if (m_exit[k] == 0) m_exit[k] = m_code[k][i];
                end else if (m_t[k] != 0 && m_cyc[k] == m_t[k] - 1) begin
                    m_to[k] = 1;
                    m_exit[k] = 32'h7fff;
                end
                if (m_cyc[k] != m_max[k]) m_cyc[k]++;
            end
            m_rdy[k] = !m_done[k] && !m_to[k];
        end
    endtask

    task automatic tick(input bit v, input int c, input int d);
        wr_valid = v;
        wr_chan  = 2'(c);
        wr_data  = 16'(d);
        @(posedge clk);
        model_edge(v, c, d & 32'hffff);
        #1 check_all();
    endtask

    task automatic rst_low();
        wr_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_low();
        repeat (3) tick(0, 0, 0);
        repeat (5) tick(1, $urandom_range(0, 3), $urandom & 32'hfffe);
        tick(1, 2, 'h7);
        tick(1, 0, 'h1);
        tick(1, 3, 'h5);
        tick(1, 1, 'h1);
        chk("dir_done_b", 64'(b_done), 1);
        chk("dir_exit_b", 64'(b_exit), 3);
        chk("dir_err_a", 64'(a_err), 1);
        chk("dir_exit_a", 64'(a_exit), 3);
        repeat (3) tick(1, 0, 'h3);

        rst_low();
        tick(0, 0, 0);
        tick(1, 0, 'h3);
        tick(1, 1, 'h1);
        rst_low();
        chk("mid_rst_chan_b", 64'(b_chan), 0);

        tick(0, 0, 0);
        tick(1, 0, 'h3);
        repeat (300) tick($urandom_range(0, 1), 3 * $urandom_range(0, 1), $urandom & 32'hffff);
        chk("tmo_b", 64'(b_to), 1);
        chk("tmo_exit_b", 64'(b_exit), 'h7fff);
        chk("tmo_ready_b", 64'(b_rdy), 0);
        chk("tmo_cyc_b", 64'(b_cyc), 60);
        chk("sat_cyc_a", 64'(a_cyc), 255);
        tick(1, 1, 'h1);
        tick(1, 2, 'h1);
        chk("keep_exit_a", 64'(a_exit), 1);
        chk("keep_done_a", 64'(a_done), 1);

        rst_low();
        tick(0, 0, 0);
        tick(1, 0, 'h1);
        tick(1, 1, 'h1);
        tick(1, 2, 'h1);
        guard = 0;
        while (m_cyc[1] != 59 && guard < 100) begin
            tick($urandom_range(0, 1), $urandom_range(0, 3), $urandom & 32'hfffe);
            guard++;
        end
        chk("race_reach", 64'(guard < 100), 1);
        tick(1, 3, 'h1);
        chk("race_done_b", 64'(b_done), 1);
        chk("race_to_b", 64'(b_to), 0);

        repeat (4) begin
            rst_low();
            repeat (80) tick($urandom_range(0, 1), $urandom_range(0, 3),
                             ($urandom & 32'hfffe) | 32'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
